// File: rtl/paint_pkg.sv
// paint_pkg: types and constants shared by brush_painter, stamp_scan and the
// pixel store. Holds the controller state enum, the canvas/erase defaults,
// the 3-bit color codes and the signed coordinate type used for stamp math.
package paint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAINT = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Color codes understood by the pixel store.
  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

  localparam int         DEF_CANVAS_DIM  = 128;
  localparam logic [2:0] DEF_ERASE_COLOR = COLOR_BLACK;

  // Signed stamp coordinate: wide enough that an 8-bit center plus or minus
  // a radius of up to 3 never wraps, so clipped positions stay recognisable.
  localparam int COORD_W = 10;
  typedef logic signed [COORD_W-1:0] coord_t;

endpackage

// File: rtl/stamp_scan.sv
// stamp_scan: row-major x/y scanner over a rectangle [start..end] on both axes.
// Ports: load copies start into the current position; advance steps x (inner
//        loop) and wraps to the next row; next_* previews the following
//        position; done flags that the current position is the last one.
module stamp_scan
  import paint_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   advance,
  input  coord_t start_x,
  input  coord_t start_y,
  input  coord_t end_x,
  input  coord_t end_y,
  output coord_t cur_x,
  output coord_t cur_y,
  output coord_t next_x,
  output coord_t next_y,
  output logic   done
);

  logic row_end;

  assign row_end = (cur_x == end_x);
  assign next_x  = row_end ? start_x : cur_x + coord_t'(1);
  assign next_y  = row_end ? cur_y + coord_t'(1) : cur_y;
  assign done    = row_end && (cur_y == end_y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (load) begin
      cur_x <= start_x;
      cur_y <= start_y;
    end else if (advance) begin
      cur_x <= next_x;
      cur_y <= next_y;
    end
  end

endmodule

// File: rtl/brush_painter.sv
// brush_painter: accepts paint/clear commands and streams pixel-store writes,
// one position per cycle. Ports: cmd_* valid/ready command input (ready only
// in IDLE, nothing queued); brush/wx/wy/newColor registered write port;
// busy while a stamp or clear sweep is in progress.
module brush_painter
  import paint_pkg::*;
#(
  parameter int         CANVAS_DIM  = DEF_CANVAS_DIM,
  parameter logic [2:0] ERASE_COLOR = DEF_ERASE_COLOR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [2:0] cmd_color,
  input  logic [1:0] cmd_radius,
  output logic       brush,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] newColor,
  output logic       busy
);

  localparam coord_t MAXC = coord_t'(CANVAS_DIM - 1);

  state_t     state_q, state_d;
  logic       lat_clear;
  logic [7:0] lat_x, lat_y;
  logic [2:0] lat_color;
  logic [1:0] lat_radius;

  logic       src_clear;
  logic [7:0] src_x, src_y;
  logic [2:0] src_color;
  logic [1:0] src_radius;
  coord_t     src_cx, src_cy, src_r;
  coord_t     start_x, start_y, end_x, end_y;
  coord_t     cur_x, cur_y, next_x, next_y;
  logic       scan_done, scan_load, scan_adv;

  logic       wr_en;
  logic [7:0] wr_x, wr_y;
  logic [2:0] wr_color;

  function automatic logic in_canvas(coord_t v);
    return (v >= 0) && (v <= MAXC);
  endfunction

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;

  // Scan bounds come straight from the command port in IDLE (so the first
  // write can be registered on the accept edge) and from the latched copy
  // while the operation runs.
  always_comb begin
    src_clear  = lat_clear;
    src_x      = lat_x;
    src_y      = lat_y;
    src_color  = lat_color;
    src_radius = lat_radius;
    if (state_q == ST_IDLE) begin
      src_clear  = cmd_clear;
      src_x      = cmd_x;
      src_y      = cmd_y;
      src_color  = cmd_color;
      src_radius = cmd_radius;
    end
    src_cx = coord_t'({2'b00, src_x});
    src_cy = coord_t'({2'b00, src_y});
    src_r  = coord_t'({8'b0, src_radius});
    if (src_clear) begin
      start_x = '0;
      start_y = '0;
      end_x   = MAXC;
      end_y   = MAXC;
    end else begin
      start_x = src_cx - src_r;
      start_y = src_cy - src_r;
      end_x   = src_cx + src_r;
      end_y   = src_cy + src_r;
    end
  end

  stamp_scan u_scan (
    .clk     (clk),
    .reset   (reset),
    .load    (scan_load),
    .advance (scan_adv),
    .start_x (start_x),
    .start_y (start_y),
    .end_x   (end_x),
    .end_y   (end_y),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .next_x  (next_x),
    .next_y  (next_y),
    .done    (scan_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the write that the output registers capture this edge.
  always_comb begin
    state_d   = state_q;
    scan_load = 1'b0;
    scan_adv  = 1'b0;
    wr_en     = 1'b0;
    wr_x      = start_x[7:0];
    wr_y      = start_y[7:0];
    wr_color  = src_clear ? ERASE_COLOR : src_color;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          scan_load = 1'b1;
          state_d   = cmd_clear ? ST_CLEAR : ST_PAINT;
          wr_en     = cmd_clear || (in_canvas(start_x) && in_canvas(start_y));
        end
      end
      ST_PAINT, ST_CLEAR: begin
        if (scan_done) begin
          state_d = ST_IDLE;
        end else begin
          scan_adv = 1'b1;
          wr_x     = next_x[7:0];
          wr_y     = next_y[7:0];
          wr_en    = lat_clear || (in_canvas(next_x) && in_canvas(next_y));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brush      <= 1'b0;
      wx         <= '0;
      wy         <= '0;
      newColor   <= '0;
      lat_clear  <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_color  <= '0;
      lat_radius <= '0;
    end else begin
      brush <= wr_en;
      // Write port holds its last values on non-write cycles.
      if (wr_en) begin
        wx       <= wr_x;
        wy       <= wr_y;
        newColor <= wr_color;
      end
      if (scan_load) begin
        lat_clear  <= cmd_clear;
        lat_x      <= cmd_x;
        lat_y      <= cmd_y;
        lat_color  <= cmd_color;
        lat_radius <= cmd_radius;
      end
    end
  end

endmodule
